// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer helpers for the dual-clock FIFO
package fifo_pkg;

    // Number of FIFO entries for a given address width
    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Binary to Gray; callers zero-extend narrower pointers and cast back down
    function automatic logic [31:0] bin2gray(input logic [31:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

    // Gray to binary by prefix XOR from the MSB; zero upper bits pass through unchanged
    function automatic logic [31:0] gray2bin(input logic [31:0] i_gray);
        logic [31:0] w_bin;
        w_bin[31] = i_gray[31];
        for (int i = 30; i >= 0; i--) begin
            w_bin[i] = w_bin[i+1] ^ i_gray[i];
        end
        return w_bin;
    endfunction

endpackage

// File: rtl/wptr_full_if.sv
// rtl/wptr_full_if.sv - write-side pointer/status bundle of the dual-clock FIFO
interface wptr_full_if #(
    parameter int ADDR_W = 4
);
    logic              i_wrEn;
    logic [ADDR_W:0]   i_rSyncPtr;
    logic [ADDR_W-1:0] o_wAddr;
    logic [ADDR_W:0]   o_wPtr;
    logic              o_full;
    logic              o_almostFull;
    logic [ADDR_W:0]   o_wrCount;
    logic              o_overflow;

    // Producer / write-domain environment side
    modport master (
        output i_wrEn, i_rSyncPtr,
        input  o_wAddr, o_wPtr, o_full, o_almostFull, o_wrCount, o_overflow
    );

    // Pointer/status generator side
    modport slave (
        input  i_wrEn, i_rSyncPtr,
        output o_wAddr, o_wPtr, o_full, o_almostFull, o_wrCount, o_overflow
    );
endinterface

// File: rtl/wptr_full.sv
// rtl/wptr_full.sv - write pointer, Gray pointer and full/level status generator
module wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_W       = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic          i_clk,
    input  logic          i_srst,
    wptr_full_if.slave    s_wif
);

    localparam int              PW       = ADDR_W + 1;
    localparam logic [ADDR_W:0] LP_AFULL = PW'(AFULL_THRESH);

    logic [ADDR_W:0] r_wBin;
    logic [ADDR_W:0] r_wPtr;
    logic            r_full;
    logic            r_almostFull;
    logic [ADDR_W:0] r_wrCount;
    logic            r_overflow;

    logic            w_accept;
    logic [ADDR_W:0] w_wBinNext;
    logic [ADDR_W:0] w_wGrayNext;
    logic [ADDR_W:0] w_rBin;
    logic [ADDR_W:0] w_fillNext;
    logic [ADDR_W:0] w_fullPattern;

    // Writes are gated by the registered full flag; the RAM enable uses the same term
    assign w_accept    = s_wif.i_wrEn & ~r_full;
    assign w_wBinNext  = r_wBin + {{ADDR_W{1'b0}}, w_accept};
    assign w_wGrayNext = PW'(bin2gray(32'(w_wBinNext)));
    assign w_rBin      = PW'(gray2bin(32'(s_wif.i_rSyncPtr)));
    assign w_fillNext  = w_wBinNext - w_rBin;

    // Full in Gray space: read pointer one lap behind means top two bits inverted
    assign w_fullPattern = {~s_wif.i_rSyncPtr[ADDR_W:ADDR_W-1], s_wif.i_rSyncPtr[ADDR_W-2:0]};

    // Pointer and status registers, all judged against the next write pointer
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_wBin       <= '0;
            r_wPtr       <= '0;
            r_full       <= 1'b0;
            r_almostFull <= 1'b0;
            r_wrCount    <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_wBin       <= w_wBinNext;
            r_wPtr       <= w_wGrayNext;
            r_full       <= (w_wGrayNext == w_fullPattern);
            r_almostFull <= (w_fillNext >= LP_AFULL);
            r_wrCount    <= w_fillNext;
            r_overflow   <= s_wif.i_wrEn & r_full;
        end
    end

    assign s_wif.o_wAddr      = r_wBin[ADDR_W-1:0];
    assign s_wif.o_wPtr       = r_wPtr;
    assign s_wif.o_full       = r_full;
    assign s_wif.o_almostFull = r_almostFull;
    assign s_wif.o_wrCount    = r_wrCount;
    assign s_wif.o_overflow   = r_overflow;

endmodule

// File: tb/tb_wptr_full.sv
// tb/tb_wptr_full.sv - scoreboard bench for the write pointer/full generator
module tb_wptr_full;

    localparam int ADDR_W = 4;
    localparam int AFULL  = 12;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PMOD   = 2 * DEPTH;

    typedef struct {
        int wptr;
        int waddr;
        int full;
        int afull;
        int count;
        int ovf;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_srst;

    wptr_full_if #(.ADDR_W(ADDR_W)) wif ();

    wptr_full #(.ADDR_W(ADDR_W), .AFULL_THRESH(AFULL)) dut (
        .i_clk  (i_clk),
        .i_srst (i_srst),
        .s_wif  (wif)
    );

    always #5 i_clk = ~i_clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    int m_wb   = 0;
    int m_full = 0;
    int m_rb   = 0;
    int m_cnt  = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Drive one cycle, predict the post-edge outputs, compare after the edge
    task automatic step(input bit srst, input bit wr, input int rb);
        exp_t e;
        int   acc;
        int   nb;
        @(negedge i_clk);
        i_srst         = srst;
        wif.i_wrEn     = wr;
        wif.i_rSyncPtr = 5'(to_gray(rb));
        m_rb           = rb;
        if (srst) begin
            e = '{0, 0, 0, 0, 0, 0};
            m_wb   = 0;
            m_full = 0;
            m_cnt  = 0;
        end else begin
            acc     = (wr && m_full == 0) ? 1 : 0;
            nb      = (m_wb + acc) % PMOD;
            m_cnt   = (nb - rb + PMOD) % PMOD;
            e.wptr  = to_gray(nb);
            e.waddr = nb % DEPTH;
            e.full  = (m_cnt == DEPTH) ? 1 : 0;
            e.afull = (m_cnt >= AFULL) ? 1 : 0;
            e.count = m_cnt;
            e.ovf   = (wr && m_full != 0) ? 1 : 0;
            m_wb    = nb;
            m_full  = e.full;
        end
        sb_q.push_back(e);
        @(posedge i_clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check_eq("wPtr",       int'(wif.o_wPtr),       e.wptr);
            check_eq("wAddr",      int'(wif.o_wAddr),      e.waddr);
            check_eq("full",       int'(wif.o_full),       e.full);
            check_eq("almostFull", int'(wif.o_almostFull), e.afull);
            check_eq("wrCount",    int'(wif.o_wrCount),    e.count);
            check_eq("overflow",   int'(wif.o_overflow),   e.ovf);
        end
    endtask

    initial begin
        i_srst         = 1'b1;
        wif.i_wrEn     = 1'b0;
        wif.i_rSyncPtr = '0;

        // Reset with write requested: write discarded
        step(1, 1, 0);
        step(1, 1, 0);

        // Fill from empty, almost-full crossing at 12, full at 16
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0);
        check_eq("fill_wPtr_gray16", int'(wif.o_wPtr), 24);

        // Overflow while full
        for (int i = 0; i < 3; i++) step(0, 1, 0);

        // Release by read pointer advance
        step(0, 0, 1);
        check_eq("release_count", int'(wif.o_wrCount), 15);

        // Write and read together across the 31 -> 0 wrap
        for (int r = 2; r <= 16; r++) step(0, 1, r);
        step(0, 1, 16);
        check_eq("wrap_full", int'(wif.o_full), 1);
        check_eq("wrap_wPtr", int'(wif.o_wPtr), 0);
        step(0, 1, 16);

        // Mixed traffic; reader never passes the writer
        for (int i = 0; i < 60; i++) begin
            int rb;
            rb = m_rb;
            if (m_cnt > 0 && $urandom_range(0, 1) == 1) rb = (rb + 1) % PMOD;
            step(0, 1'($urandom_range(0, 1)), rb);
        end

        // Reset mid-operation at count 7
        step(1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0);
        check_eq("pre_reset_count", int'(wif.o_wrCount), 7);
        step(1, 1, 0);
        step(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wptr_full.md
Name: wptr_full

Overview:
Write-domain pointer and status generator for the dual-clock FIFO. It advances the binary write address on each accepted write and produces the registered Gray write pointer, which the two-flop pointer synchronizer carries into the read domain. It compares the read pointer, already synchronized into the write domain, against its next write pointer to produce registered full, almost-full, fill-level and overflow status. It sits directly upstream of the read-domain synchronizer and directly downstream of the read-to-write synchronizer.

Parameters:
ADDR_W, 4, FIFO address width; depth is 2**ADDR_W entries; pointers are ADDR_W+1 bits; legal range ADDR_W >= 2.
AFULL_THRESH, 12, fill level at or above which o_almostFull asserts; legal range 1..2**ADDR_W.

Ports:
i_clk  input  1  write-domain clock.
i_srst  input  1  reset, synchronous to i_clk, active-high.
i_wrEn  input  1  write request from the producer.
i_rSyncPtr  input  ADDR_W+1  Gray read pointer, already synchronized into the write domain.
o_wAddr  output  ADDR_W  RAM write address (low ADDR_W bits of the binary write pointer).
o_wPtr  output  ADDR_W+1  registered Gray write pointer, sent to the write-to-read synchronizer.
o_full  output  1  FIFO full; writes are rejected while high.
o_almostFull  output  1  fill level >= AFULL_THRESH.
o_wrCount  output  ADDR_W+1  conservative fill level, 0..2**ADDR_W.
o_overflow  output  1  one-cycle pulse when a write is requested while full.

Behaviour:
- Clock and reset: single clock i_clk; reset i_srst is synchronous and active-high.
- Reset: on an i_clk edge with i_srst=1, all registers clear: wBin=0, o_wPtr=0, o_wAddr=0, o_full=0, o_almostFull=0, o_wrCount=0, o_overflow=0. i_srst overrides i_wrEn; a write in the reset cycle is discarded.
- Write acceptance: accept = i_wrEn & ~o_full, using the registered o_full. The RAM write-enable is derived outside this block from the same expression.
- Next-pointer calculation:
  - wBinNext = wBin + accept, wrapping modulo 2**(ADDR_W+1).
  - wGrayNext = wBinNext ^ (wBinNext >> 1).
- Registered updates each edge:
  - wBin <= wBinNext and o_wPtr <= wGrayNext.
  - o_wAddr = wBin[ADDR_W-1:0], taken straight from the register.
- Full:
  - o_full <= (wGrayNext == {~i_rSyncPtr[ADDR_W:ADDR_W-1], i_rSyncPtr[ADDR_W-2:0]}).
  - Full therefore asserts on the same edge as the write that fills the FIFO. There is no extra cycle of latency.
- Fill level:
  - rBin = gray-to-binary of i_rSyncPtr (combinational).
  - o_wrCount <= wBinNext - rBin, computed modulo 2**(ADDR_W+1).
- Almost full: o_almostFull <= ((wBinNext - rBin) >= AFULL_THRESH).
- Overflow: o_overflow <= i_wrEn & o_full, a single-cycle pulse per rejected request. Pointers are unchanged on a rejected request.
- Pessimism: because i_rSyncPtr lags the true read pointer by the synchronizer latency, full, almostFull and count release late. They never report space that does not exist.
- Full release: when i_rSyncPtr advances while o_full=1 and no write is accepted, o_full deasserts on the next edge.
- Wrap-around: the extra MSB distinguishes full from empty across the 2**ADDR_W boundary.
  - Pointer bin 31 -> 0 (ADDR_W=4) is a normal increment.
  - The Gray code changes exactly one bit per accepted write, which is the invariant the downstream synchronizer relies on.
- Simultaneous events: write accepted in the same cycle i_rSyncPtr changes — both are folded into the next-state compare. No priority is needed.
- Reset domain: read-side reset coordination is outside this block.

Decomposition:
- Shared package fifo_pkg:
  - function bin2gray(ADDR_W+1 bits), function gray2bin(ADDR_W+1 bits).
  - localparam-style helper for the depth, 2**ADDR_W.
- The read-side pointer/empty block reuses the same functions.
- No sub-module: the logic is one register set plus combinational next-state.

Test Plan (ADDR_W=4, AFULL_THRESH=12):
1. Reset: i_srst=1 for 2 edges with i_wrEn=1 -> o_wPtr=5'b00000, o_wAddr=0, o_full=0, o_wrCount=0, o_overflow=0.
2. Fill from empty: i_rSyncPtr=0, 16 consecutive writes -> o_wrCount steps 1..16; after the 16th edge o_full=1, o_wPtr=5'b11000 (gray 16), o_wAddr=0.
3. Almost full: during test 2 -> o_almostFull=0 with count=11; o_almostFull=1 on the edge where count becomes 12.
4. Overflow: hold i_wrEn=1 while full -> o_overflow=1 for each rejected cycle; o_wPtr stays 5'b11000; o_wrCount stays 16.
5. Release and wrap: while full, set i_rSyncPtr=5'b00001 (bin 1) -> next edge o_full=0, o_wrCount=15. Continue writing/reading until wBin passes 31 -> 0 with i_rSyncPtr=5'b11000 -> o_full=1 when o_wPtr=5'b00000.
6. Reset mid-operation: at count=7 assert i_srst with i_wrEn=1 -> next edge all outputs 0; the write in the reset cycle is not counted.
